// File: rtl/cap_seq_ctrl.sv
// Capacitor charge/discharge and IGBT fire sequencer with dead-time and timeouts.
// Optional FIRE_INTERLOCK_EN: fire in READY requires the selected caps still at setpoint.
module cap_seq_ctrl #(
  parameter logic [31:0] CHG_TIMEOUT = 32'd50_000_000,
  parameter logic [15:0] DEAD_TIME   = 16'd10,
  parameter logic [15:0] FIRE_WIDTH  = 16'd50
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       charge_req,
  input  logic       dis_req,
  input  logic [1:0] cap_sel,
  input  logic [1:0] cap_reached,
  input  logic       fire_req,
  input  logic [4:0] fire_mask,
  input  logic       abort,
  input  logic       fault_clr,
  output logic [1:0] CAP_charge_flag,
  output logic [1:0] CAP_discharge_flag,
  output logic [4:0] IGBT_on_EN,
  output logic       ready,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_DISCHARGE = 3'd2,
    ST_READY     = 3'd3,
    ST_DEAD      = 3'd4,
    ST_FIRE      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [31:0] CHG_LAST  = CHG_TIMEOUT - 32'd1;
  localparam logic [31:0] DEAD_LAST = {16'd0, DEAD_TIME} - 32'd1;
  // A zero fire width still produces a single pulse cycle
  localparam logic [31:0] FIRE_LAST = (FIRE_WIDTH == 16'd0) ? 32'd0 : ({16'd0, FIRE_WIDTH} - 32'd1);

  state_t      state_r, state_s;
  logic [31:0] timer_r;
  logic [1:0]  sel_q, sel_s;
  logic [4:0]  mask_q, mask_s;
  logic [1:0]  code_r, code_s;
  logic        reached_s;
  logic [1:0]  chg_flag_s, dis_flag_s;
  logic [4:0]  igbt_s;

  assign reached_s = ((cap_reached & sel_q) == sel_q);
  assign state     = state_r;

  // Next-state, latched selections and fault code
  always_comb begin
    state_s = state_r;
    sel_s   = sel_q;
    mask_s  = mask_q;
    code_s  = code_r;
    if (abort && (state_r != ST_IDLE) && (state_r != ST_FAULT)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dis_req && (cap_sel != 2'b00)) begin
            state_s = ST_DISCHARGE;
            sel_s   = cap_sel;
          end else if (charge_req && (cap_sel != 2'b00)) begin
            state_s = ST_CHARGE;
            sel_s   = cap_sel;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CHARGE: begin
          if (reached_s) begin
            state_s = ST_READY;
          end else if (timer_r == CHG_LAST) begin
            state_s = ST_FAULT;
            code_s  = 2'b01;
          end else begin
            state_s = ST_CHARGE;
          end
        end
        ST_DISCHARGE: begin
          if (reached_s) begin
            state_s = ST_IDLE;
          end else if (timer_r == CHG_LAST) begin
            state_s = ST_FAULT;
            code_s  = 2'b10;
          end else begin
            state_s = ST_DISCHARGE;
          end
        end
        ST_READY: begin
          if (fire_req && (fire_mask != 5'b00000)) begin
`ifdef FIRE_INTERLOCK_EN
            if (reached_s) begin
              mask_s  = fire_mask;
              state_s = (DEAD_TIME == 16'd0) ? ST_FIRE : ST_DEAD;
            end else begin
              state_s = ST_FAULT;
              code_s  = 2'b11;
            end
`else
            mask_s  = fire_mask;
            state_s = (DEAD_TIME == 16'd0) ? ST_FIRE : ST_DEAD;
`endif
          end else if (charge_req && (cap_sel != 2'b00)) begin
            state_s = ST_CHARGE;
            sel_s   = cap_sel;
          end else begin
            state_s = ST_READY;
          end
        end
        ST_DEAD: begin
          if (timer_r == DEAD_LAST) begin
            state_s = ST_FIRE;
          end else begin
            state_s = ST_DEAD;
          end
        end
        ST_FIRE: begin
          if (timer_r == FIRE_LAST) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FIRE;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_s = ST_IDLE;
            code_s  = 2'b00;
          end else begin
            state_s = ST_FAULT;
          end
        end
        default: begin
          state_s = ST_IDLE;
          code_s  = 2'b00;
        end
      endcase
    end
  end

  // Drive values decoded from the next state so the registered outputs line up with state_r
  always_comb begin
    chg_flag_s = 2'b00;
    dis_flag_s = 2'b00;
    igbt_s     = 5'b00000;
    case (state_s)
      ST_CHARGE:    chg_flag_s = sel_s;
      ST_DISCHARGE: dis_flag_s = sel_s;
      ST_FIRE:      igbt_s     = mask_s;
      default:      igbt_s     = 5'b00000;
    endcase
  end

  // State, timer, latches and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r            <= ST_IDLE;
      timer_r            <= 32'd0;
      sel_q              <= 2'b00;
      mask_q             <= 5'b00000;
      code_r             <= 2'b00;
      CAP_charge_flag    <= 2'b00;
      CAP_discharge_flag <= 2'b00;
      IGBT_on_EN         <= 5'b00000;
      ready              <= 1'b0;
      fault              <= 1'b0;
      fault_code         <= 2'b00;
    end else begin
      state_r            <= state_s;
      timer_r            <= (state_s != state_r) ? 32'd0 : (timer_r + 32'd1);
      sel_q              <= sel_s;
      mask_q             <= mask_s;
      code_r             <= code_s;
      CAP_charge_flag    <= chg_flag_s;
      CAP_discharge_flag <= dis_flag_s;
      IGBT_on_EN         <= igbt_s;
      ready              <= (state_s == ST_READY);
      fault              <= (state_s == ST_FAULT);
      fault_code         <= code_s;
    end
  end

endmodule

// File: tb/tb_cap_seq_ctrl.sv
// Directed self-checking bench for cap_seq_ctrl (main instance plus a zero dead-time/width instance).
module tb_cap_seq_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       charge_req = 1'b0, dis_req = 1'b0, fire_req = 1'b0, abort = 1'b0, fault_clr = 1'b0;
  logic [1:0] cap_sel = 2'b00, cap_reached = 2'b00;
  logic [4:0] fire_mask = 5'b00000;
  logic [1:0] chg_a, dis_a, code_a, chg_b, dis_b, code_b;
  logic [4:0] igbt_a, igbt_b;
  logic       ready_a, fault_a, ready_b, fault_b;
  logic [2:0] state_a, state_b;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cnt;
  logic [4:0] drv_or;

  always #5 sys_clk = ~sys_clk;

  cap_seq_ctrl #(.CHG_TIMEOUT(32'd100), .DEAD_TIME(16'd10), .FIRE_WIDTH(16'd50)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .charge_req(charge_req), .dis_req(dis_req),
    .cap_sel(cap_sel), .cap_reached(cap_reached), .fire_req(fire_req), .fire_mask(fire_mask),
    .abort(abort), .fault_clr(fault_clr), .CAP_charge_flag(chg_a), .CAP_discharge_flag(dis_a),
    .IGBT_on_EN(igbt_a), .ready(ready_a), .fault(fault_a), .fault_code(code_a), .state(state_a));

  cap_seq_ctrl #(.CHG_TIMEOUT(32'd100), .DEAD_TIME(16'd0), .FIRE_WIDTH(16'd0)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .charge_req(charge_req), .dis_req(dis_req),
    .cap_sel(cap_sel), .cap_reached(cap_reached), .fire_req(fire_req), .fire_mask(fire_mask),
    .abort(abort), .fault_clr(fault_clr), .CAP_charge_flag(chg_b), .CAP_discharge_flag(dis_b),
    .IGBT_on_EN(igbt_b), .ready(ready_b), .fault(fault_b), .fault_code(code_b), .state(state_b));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 sys_rst = 1'b1;
    #1;
    check_val("rst_state", {29'd0, state_a}, 32'd0);
    check_val("rst_outs", {16'd0, chg_a, dis_a, igbt_a, ready_a, fault_a, code_a}, 32'd0);
    step(); step();
    sys_rst = 1'b0;
    step();
    check_val("idle_state", {29'd0, state_a}, 32'd0);

    // Charge both caps, partial then full reach
    cap_sel = 2'b11; charge_req = 1'b1;
    step();
    charge_req = 1'b0;
    check_val("chg_state", {29'd0, state_a}, 32'd1);
    check_val("chg_flag", {30'd0, chg_a}, 32'd3);
    check_val("chg_dis_flag", {30'd0, dis_a}, 32'd0);
    repeat (4) step();
    cap_reached = 2'b01;
    repeat (15) step();
    check_val("chg_partial", {29'd0, state_a}, 32'd1);
    cap_reached = 2'b11;
    step();
    check_val("ready_state", {29'd0, state_a}, 32'd3);
    check_val("ready_flag", {31'd0, ready_a}, 32'd1);
    check_val("ready_noflags", {30'd0, chg_a | dis_a}, 32'd0);
    check_val("b_ready", {29'd0, state_b}, 32'd3);

    // Zero mask is ignored
    fire_req = 1'b1; fire_mask = 5'b00000;
    step();
    check_val("mask0_ignored", {29'd0, state_a}, 32'd3);

    // Fire sequence: 10 dead cycles then 50 fire cycles
    fire_mask = 5'b10101;
    step();
    fire_req = 1'b0;
    check_val("dead_state", {29'd0, state_a}, 32'd4);
    check_val("b_fire_direct", {29'd0, state_b}, 32'd5);
    check_val("b_igbt", {27'd0, igbt_b}, 32'h15);
    drv_or = igbt_a | {3'd0, chg_a} | {3'd0, dis_a};
    cnt = 1;
    step();
    check_val("b_fire_one", {29'd0, state_b}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      if (state_a != 3'd4) break;
      cnt++;
      drv_or = drv_or | igbt_a | {3'd0, chg_a} | {3'd0, dis_a};
      step();
    end
    check_val("dead_cycles", cnt, 32'd10);
    check_val("dead_drives", {27'd0, drv_or}, 32'd0);
    check_val("fire_state", {29'd0, state_a}, 32'd5);
    check_val("fire_igbt", {27'd0, igbt_a}, 32'h15);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (state_a != 3'd5) break;
      cnt++;
      step();
    end
    check_val("fire_cycles", cnt, 32'd50);
    check_val("fire_end_state", {29'd0, state_a}, 32'd0);
    check_val("fire_end_igbt", {27'd0, igbt_a}, 32'd0);

    // Charge timeout
    cap_reached = 2'b00; cap_sel = 2'b01; charge_req = 1'b1;
    step();
    charge_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (state_a != 3'd1) break;
      cnt++;
      step();
    end
    check_val("tmo_cycles", cnt, 32'd100);
    check_val("tmo_state", {29'd0, state_a}, 32'd6);
    check_val("tmo_fault", {31'd0, fault_a}, 32'd1);
    check_val("tmo_code", {30'd0, code_a}, 32'd1);
    check_val("tmo_drives", {27'd0, igbt_a | {3'd0, chg_a} | {3'd0, dis_a}}, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("fault_abort_ign", {29'd0, state_a}, 32'd6);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check_val("clr_state", {29'd0, state_a}, 32'd0);
    check_val("clr_code", {30'd0, code_a}, 32'd0);
    check_val("clr_fault", {31'd0, fault_a}, 32'd0);

    // Simultaneous requests: discharge wins
    cap_sel = 2'b10; charge_req = 1'b1; dis_req = 1'b1;
    step();
    charge_req = 1'b0; dis_req = 1'b0;
    check_val("sim_state", {29'd0, state_a}, 32'd2);
    check_val("sim_dis_flag", {30'd0, dis_a}, 32'd2);
    check_val("sim_chg_flag", {30'd0, chg_a}, 32'd0);
    cap_reached = 2'b10;
    step();
    check_val("dis_done", {29'd0, state_a}, 32'd0);

    // cap_sel==0 causes no transition
    cap_sel = 2'b00; charge_req = 1'b1;
    step();
    charge_req = 1'b0;
    check_val("sel0_idle", {29'd0, state_a}, 32'd0);

    // Abort on FIRE cycle 20
    cap_sel = 2'b11; cap_reached = 2'b11; charge_req = 1'b1;
    step();
    charge_req = 1'b0;
    step();
    check_val("ab_ready", {29'd0, state_a}, 32'd3);
    fire_req = 1'b1; fire_mask = 5'b10101;
    step();
    fire_req = 1'b0;
    repeat (10) step();
    check_val("ab_fire1", {29'd0, state_a}, 32'd5);
    repeat (19) step();
    check_val("ab_fire20", {29'd0, state_a}, 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("ab_state", {29'd0, state_a}, 32'd0);
    check_val("ab_igbt", {27'd0, igbt_a}, 32'd0);

    // Asynchronous reset mid-CHARGE
    cap_reached = 2'b00; charge_req = 1'b1;
    step();
    charge_req = 1'b0;
    check_val("ar_charging", {30'd0, chg_a}, 32'd3);
    #2 sys_rst = 1'b1;
    #1;
    check_val("ar_state", {29'd0, state_a}, 32'd0);
    check_val("ar_outs", {16'd0, chg_a, dis_a, igbt_a, ready_a, fault_a, code_a}, 32'd0);
    step();
    sys_rst = 1'b0;
    step();

    // Fire after cap_reached drops in READY
    cap_reached = 2'b11; charge_req = 1'b1;
    step();
    charge_req = 1'b0;
    step();
    check_val("il_ready", {29'd0, state_a}, 32'd3);
    cap_reached = 2'b01; fire_req = 1'b1; fire_mask = 5'b10101;
    step();
    fire_req = 1'b0;
`ifdef FIRE_INTERLOCK_EN
    check_val("il_state", {29'd0, state_a}, 32'd6);
    check_val("il_code", {30'd0, code_a}, 32'd3);
    drv_or = igbt_a;
    repeat (70) begin
      step();
      drv_or = drv_or | igbt_a;
    end
    check_val("il_no_igbt", {27'd0, drv_or}, 32'd0);
`else
    check_val("il_off_dead", {29'd0, state_a}, 32'd4);
    check_val("il_off_code", {30'd0, code_a}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cap_seq_ctrl.md
CAP_SEQ_CTRL -- requirements
Module: cap_seq_ctrl

Interface
REQ-001 Parameter CHG_TIMEOUT, 32'd50_000_000, max cycles allowed in CHARGE or DISCHARGE before fault.
REQ-002 Parameter DEAD_TIME, 16'd10, all-off cycles between READY and FIRE.
REQ-003 Parameter FIRE_WIDTH, 16'd50, cycles IGBT_on_EN is held in FIRE.
REQ-004 sys_clk  in  1  single system clock, all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 charge_req  in  1  request to charge the caps selected by cap_sel; level, sampled per cycle.
REQ-007 dis_req  in  1  request to discharge the caps selected by cap_sel.
REQ-008 cap_sel  in  2  bit0 = resonant cap 1, bit1 = resonant cap 2.
REQ-009 cap_reached  in  2  per-cap "voltage at setpoint" flags from the cap-voltage monitor.
REQ-010 fire_req  in  1  request to fire IGBTs; fire_mask  in  5  IGBT select pattern.
REQ-011 abort  in  1  immediate stop; fault_clr  in  1  fault acknowledge.
REQ-012 CAP_charge_flag  out  2;  CAP_discharge_flag  out  2;  IGBT_on_EN  out  5.
REQ-013 ready  out  1;  fault  out  1;  fault_code  out  2;  state  out  3.

Function
REQ-014 States: IDLE=0, CHARGE=1, DISCHARGE=2, READY=3, DEAD=4, FIRE=5, FAULT=6. Codes 7 are unreachable and recover to IDLE.
REQ-015 All outputs are registered. An output that corresponds to a state is valid in the same cycle that the state register holds that state.
REQ-016 IDLE: dis_req with cap_sel!=0 goes to DISCHARGE. Otherwise charge_req with cap_sel!=0 goes to CHARGE. dis_req wins when both are asserted. cap_sel is latched into sel_q on the transition. cap_sel==0 causes no transition.
REQ-017 Latency: a request sampled in cycle N puts the new state and its flags in cycle N+1.
REQ-018 A 32-bit timer clears on every state change and increments each cycle while the state holds.
REQ-019 CHARGE: CAP_charge_flag=sel_q. Go to READY when (cap_reached & sel_q)==sel_q. Go to FAULT with code 2'b01 when timer==CHG_TIMEOUT-1. If both conditions occur in the same cycle, reached wins.
REQ-020 DISCHARGE: CAP_discharge_flag=sel_q. Go to IDLE when (cap_reached & sel_q)==sel_q. Go to FAULT with code 2'b10 on timeout. Reached wins over timeout.
REQ-021 READY: ready=1. A fire_req with fire_mask!=0 latches fire_mask into mask_q and goes to DEAD. Otherwise charge_req goes to CHARGE (top-up, sel_q re-latched). fire_mask==0 is ignored.
REQ-022 DEAD: all drive outputs are 0 for exactly DEAD_TIME cycles, then FIRE. DEAD_TIME=0 means FIRE directly follows READY.
REQ-023 FIRE: IGBT_on_EN=mask_q for exactly FIRE_WIDTH cycles, then IDLE. FIRE_WIDTH=0 is treated as 1.
REQ-024 Mutual exclusion:
- CAP_charge_flag and CAP_discharge_flag are never both nonzero.
- IGBT_on_EN is nonzero only in FIRE.
- CAP flags are zero in FIRE and DEAD.
REQ-025 abort in any state other than IDLE or FAULT goes to IDLE next cycle with all drives 0. abort has priority over every other transition.
REQ-026 FAULT: fault=1, fault_code is held, all drives are 0. Only fault_clr exits, to IDLE, and clears fault_code. abort is ignored in FAULT.
REQ-027 Requests arriving in states that do not consume them are dropped, not queued.

Reset
REQ-028 While sys_rst=1:
- state=IDLE; timer, sel_q and mask_q are 0.
- All outputs are 0, including fault_code.
REQ-029 Reset mid-FIRE or mid-CHARGE removes all drives asynchronously, with no clock edge required.

Configuration
REQ-030 Macro FIRE_INTERLOCK_EN.
- Defined: in READY, fire_req is accepted only if (cap_reached & sel_q)==sel_q in the sampling cycle. Otherwise the FSM goes to FAULT with code 2'b11.
- Undefined: fire_req is accepted in READY regardless of cap_reached.

Verification
REQ-031 Charge: cap_sel=2'b11, charge_req 1 cycle; cap_reached=2'b01 at +5, 2'b11 at +20 -> CAP_charge_flag=2'b11 from N+1; READY at +21; flags 0 in READY.
REQ-032 Fire with DEAD_TIME=10, FIRE_WIDTH=50: in READY, fire_req with fire_mask=5'b10101 -> 10 cycles all-off, then IGBT_on_EN=5'b10101 for exactly 50 cycles, then IDLE.
REQ-033 Timeout with CHG_TIMEOUT=100: charge_req, cap_reached held 0 -> FAULT at cycle 100 with fault_code=01. fault_clr -> IDLE with code cleared.
REQ-034 Simultaneous requests: charge_req and dis_req together with cap_sel=2'b10 -> DISCHARGE, CAP_discharge_flag=2'b10, CAP_charge_flag=0.
REQ-035 Abort: assert abort on FIRE cycle 20 -> IGBT_on_EN=0 and state=IDLE next cycle. Assert sys_rst mid-CHARGE -> all outputs 0 immediately.
REQ-036 Interlock (FIRE_INTERLOCK_EN defined): in READY, cap_reached drops to 2'b01 with sel_q=2'b11, then fire_req -> FAULT with code 11 and IGBT_on_EN never asserted.
